// File: rtl/mprj_cfg_pkg.sv
// mprj_cfg_pkg: shared constants for the user-IO configuration controller.
// Register word offsets, transfer FSM states and default parameters.
package mprj_cfg_pkg;

    localparam logic [31:0] DEF_BASE_ADR   = 32'h2600_0000;
    localparam int          DEF_NUM_IO     = 38;
    localparam int          DEF_CFG_W      = 13;
    localparam int          DEF_NUM_CHAINS = 2;
    localparam int          DEF_PWR_W      = 4;
    localparam logic [12:0] DEF_CFG_RST    = 13'h0403;

    // Word offsets (byte offset / 4) inside the 4 KiB window
    localparam logic [9:0] OFS_XFER   = 10'h000;
    localparam logic [9:0] OFS_PWR    = 10'h001;
    localparam logic [9:0] OFS_CLKDIV = 10'h002;
    localparam logic [9:0] OFS_IO     = 10'h008;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD,
        ST_DONE
    } xfer_state_e;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mprj_cfg_shifter.sv
// mprj_cfg_shifter: serial loader for the per-IO configuration chains.
// Shifts all chains in lockstep, highest IO and MSB first, then pulses load.
module mprj_cfg_shifter
    import mprj_cfg_pkg::*;
#(
    parameter int NUM_IO     = DEF_NUM_IO,
    parameter int CFG_W      = DEF_CFG_W,
    parameter int NUM_CHAINS = DEF_NUM_CHAINS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              div,
    input  logic [NUM_IO*CFG_W-1:0] cfg_flat,
    output logic                    serial_clock,
    output logic                    serial_load,
    output logic [NUM_CHAINS-1:0]   serial_data,
    output logic                    busy
);

    localparam int P      = NUM_IO / NUM_CHAINS;
    localparam int IO_CW  = (P > 1) ? $clog2(P) : 1;
    localparam int BIT_CW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
    localparam logic [IO_CW-1:0]  IO_LAST  = IO_CW'(P - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(CFG_W - 1);

    xfer_state_e         state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          div_q, div_d;
    logic [IO_CW-1:0]    io_q, io_d;
    logic [BIT_CW-1:0]   bit_q, bit_d;
    logic                tick;
    logic [CFG_W-1:0]    chain_io [NUM_CHAINS][P];

    // View the flat config bus as [chain][io-within-chain]
    always_comb begin
        for (int c = 0; c < NUM_CHAINS; c++) begin
            for (int j = 0; j < P; j++) begin
                chain_io[c][j] = cfg_flat[(c*P + j)*CFG_W +: CFG_W];
            end
        end
    end

    // State, divider and bit/IO counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 8'd1;
            io_q    <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            io_q    <= io_d;
            bit_q   <= bit_d;
        end
    end

    // Next state: every state lasts div_q cycles; divider latched at start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        io_d    = io_q;
        bit_d   = bit_q;
        tick    = (cnt_q == div_q - 8'd1);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT_LO;
                    cnt_d   = '0;
                    div_d   = (div == 8'd0) ? 8'd1 : div;
                    io_d    = IO_LAST;
                    bit_d   = BIT_LAST;
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    cnt_d = '0;
                    if (io_q == '0 && bit_q == '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SHIFT_LO;
                        if (bit_q == '0) begin
                            bit_d = BIT_LAST;
                            io_d  = io_q - IO_CW'(1);
                        end else begin
                            bit_d = bit_q - BIT_CW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial outputs decoded from the state; data low outside shifting
    always_comb begin
        serial_clock = (state_q == ST_SHIFT_HI);
        serial_load  = (state_q == ST_LOAD);
        busy         = (state_q != ST_IDLE);
        serial_data  = '0;
        if (state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI) begin
            for (int c = 0; c < NUM_CHAINS; c++) begin
                serial_data[c] = chain_io[c][io_q][bit_q];
            end
        end
    end

endmodule

// File: rtl/mprj_io_cfg_ctrl.sv
// mprj_io_cfg_ctrl: Wishbone register file for user-IO config and power.
// Optional MPRJ_CFG_CLKDIV_EN adds a programmable serial clock divider.
module mprj_io_cfg_ctrl
    import mprj_cfg_pkg::*;
#(
    parameter logic [31:0]      BASE_ADR   = DEF_BASE_ADR,
    parameter int               NUM_IO     = DEF_NUM_IO,
    parameter int               CFG_W      = DEF_CFG_W,
    parameter int               NUM_CHAINS = DEF_NUM_CHAINS,
    parameter int               PWR_W      = DEF_PWR_W,
    parameter logic [CFG_W-1:0] CFG_RST    = CFG_W'(DEF_CFG_RST)
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [PWR_W-1:0]      mprj_pwr_o,
    output logic                  serial_clock_o,
    output logic                  serial_load_o,
    output logic [NUM_CHAINS-1:0] serial_data_o,
    output logic                  xfer_busy_o
);

    localparam logic [9:0] IO_END = OFS_IO + 10'(NUM_IO);

    logic [CFG_W-1:0]        io_cfg [NUM_IO];
    logic [NUM_IO*CFG_W-1:0] cfg_flat;
    logic [PWR_W-1:0]        pwr_q;
    logic [7:0]              div_eff;
    logic                    ack_q, done_q, start_q, busy;
    logic [31:0]             dat_q;
    logic                    wb_req, wb_take, wr_take;
    logic [9:0]              word, io_idx;
    logic                    is_xfer, is_pwr, is_div, is_io;
    logic [CFG_W-1:0]        io_rd;
    logic [31:0]             rdata, pwr_m, io_m, div_m;
    logic                    unused_bits;

`ifdef MPRJ_CFG_CLKDIV_EN
    logic [7:0] clkdiv_q;
    assign div_eff = clkdiv_q;
`else
    assign div_eff = 8'd1;
`endif

    assign word    = wbs_adr_i[11:2];
    assign io_idx  = word - OFS_IO;
    assign is_xfer = (word == OFS_XFER);
    assign is_pwr  = (word == OFS_PWR);
    assign is_div  = (word == OFS_CLKDIV);
    assign is_io   = (word >= OFS_IO) && (word < IO_END);

    // One ack per strobe: done_q blocks re-acking until the request drops
    assign wb_req  = wbs_cyc_i && wbs_stb_i &&
                     (wbs_adr_i[31:12] == BASE_ADR[31:12]);
    assign wb_take = wb_req && !done_q;
    assign wr_take = wb_take && wbs_we_i;

    // Read mux and byte-merged write values for the addressed register
    always_comb begin
        io_rd = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (io_idx == 10'(i)) io_rd = io_cfg[i];
        end
        rdata = '0;
        unique case (1'b1)
            is_xfer: rdata = {31'b0, busy};
            is_pwr:  rdata = 32'(pwr_q);
`ifdef MPRJ_CFG_CLKDIV_EN
            is_div:  rdata = 32'(clkdiv_q);
`else
            is_div:  rdata = '0;
`endif
            is_io:   rdata = 32'(io_rd);
            default: rdata = '0;
        endcase
        pwr_m = be_merge(32'(pwr_q), wbs_dat_i, wbs_sel_i);
        io_m  = be_merge(32'(io_rd), wbs_dat_i, wbs_sel_i);
`ifdef MPRJ_CFG_CLKDIV_EN
        div_m = be_merge(32'(clkdiv_q), wbs_dat_i, wbs_sel_i);
`else
        div_m = '0;
`endif
    end

    assign unused_bits = ^{wbs_adr_i[1:0], pwr_m[31:PWR_W],
                           io_m[31:CFG_W], div_m};

    // Bus handshake, read data and transfer start request
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q   <= wb_take;
            done_q  <= wb_req;
            dat_q   <= (wb_take && !wbs_we_i) ? rdata : '0;
            start_q <= wr_take && is_xfer && wbs_sel_i[0] &&
                       wbs_dat_i[0] && !busy && !start_q;
        end
    end

    // Power and divider registers accept writes at any time
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pwr_q <= '0;
`ifdef MPRJ_CFG_CLKDIV_EN
            clkdiv_q <= 8'd1;
`endif
        end else begin
            if (wr_take && is_pwr) pwr_q <= pwr_m[PWR_W-1:0];
`ifdef MPRJ_CFG_CLKDIV_EN
            if (wr_take && is_div) clkdiv_q <= div_m[7:0];
`endif
        end
    end

    // IO configs are frozen while the chains are being loaded
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_IO; i++) io_cfg[i] <= CFG_RST;
        end else if (wr_take && is_io && !busy && !start_q) begin
            for (int i = 0; i < NUM_IO; i++) begin
                if (io_idx == 10'(i)) io_cfg[i] <= io_m[CFG_W-1:0];
            end
        end
    end

    // Flatten configs for the shifter, IO i at bits [i*CFG_W +: CFG_W]
    always_comb begin
        for (int i = 0; i < NUM_IO; i++) begin
            cfg_flat[i*CFG_W +: CFG_W] = io_cfg[i];
        end
    end

    mprj_cfg_shifter #(
        .NUM_IO     (NUM_IO),
        .CFG_W      (CFG_W),
        .NUM_CHAINS (NUM_CHAINS)
    ) u_shifter (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .start        (start_q),
        .div          (div_eff),
        .cfg_flat     (cfg_flat),
        .serial_clock (serial_clock_o),
        .serial_load  (serial_load_o),
        .serial_data  (serial_data_o),
        .busy         (busy)
    );

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign mprj_pwr_o  = pwr_q;
    assign xfer_busy_o = busy;

endmodule

// File: tb/tb_mprj_io_cfg_ctrl.sv
// tb_mprj_io_cfg_ctrl: randomized checks against a register/stream model.
// Define MPRJ_CFG_CLKDIV_EN for both DUT and bench to cover the divider.
module tb_mprj_io_cfg_ctrl;

    localparam logic [31:0] BASE   = 32'h2600_0000;
    localparam logic [31:0] A_XFER = BASE;
    localparam logic [31:0] A_PWR  = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam int NIO   = 38;
    localparam int CW    = 13;
    localparam int P     = 19;
    localparam int N     = P * CW;
    localparam int BUSY1 = 2 * N + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic [3:0]  pwr;
    logic        sclk, sload;
    logic [1:0]  sdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [12:0] m_cfg [NIO];
    logic [3:0]  m_pwr;
    logic        cap [2][N];

    always #5 clk = ~clk;

    mprj_io_cfg_ctrl dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_cyc_i      (cyc),
        .wbs_stb_i      (stb),
        .wbs_we_i       (we),
        .wbs_sel_i      (sel),
        .wbs_adr_i      (adr),
        .wbs_dat_i      (dat_i),
        .wbs_ack_o      (ack),
        .wbs_dat_o      (dat_o),
        .mprj_pwr_o     (pwr),
        .serial_clock_o (sclk),
        .serial_load_o  (sload),
        .serial_data_o  (sdata),
        .xfer_busy_o    (busy)
    );

    function automatic logic [31:0] io_adr(input int i);
        return BASE + 32'h20 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] bytes_merge(
        input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NIO; i++) m_cfg[i] = 13'h0403;
        m_pwr = 4'h0;
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             output logic [31:0] rd, output logic ok);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
        ok = 0; rd = '0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk); #1;
            if (ack) begin ok = 1; rd = dat_o; end
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; logic ok;
        wb_access(1'b1, a, d, s, rd, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s write ack: got %b expected 1", nm, ok);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] rd; logic ok;
        wb_access(1'b0, a, 32'h0, 4'hF, rd, ok);
        n_tests++;
        if (ok !== 1'b1 || rd !== exp) begin
            n_fail++;
            $display("FAIL %s read: got ack=%b data=%h expected data=%h",
                     nm, ok, rd, exp);
        end
    endtask

    task automatic run_xfer(input int d, input int stop_rise);
        logic [31:0] rd; logic ok;
        int first_busy, busy_len, rises, last_rise, per_err, hold_err;
        int load_pulses, load_len, idle_err, bad_bits, limit, io, b;
        logic prev_clk, prev_load, seen, stopped;
        logic [1:0] held;
        wb_access(1'b1, A_XFER, 32'h1, 4'hF, rd, ok);
        n_tests++;
        if (ok !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL xfer_start: got ack=%b busy=%b expected 1,0",
                     ok, busy);
        end
        first_busy = -1; busy_len = 0; rises = 0; last_rise = 0;
        per_err = 0; hold_err = 0; load_pulses = 0; load_len = 0;
        idle_err = 0; prev_clk = 0; prev_load = 0; seen = 0;
        stopped = 0; held = 0;
        limit = d * BUSY1 + 40;
        for (int s = 0; s < limit; s++) begin
            @(negedge clk);
            if (busy) begin
                if (first_busy < 0) first_busy = s;
                busy_len++;
                seen = 1;
            end else if (seen) begin
                break;
            end
            if (sclk && !prev_clk) begin
                if (rises < N) begin
                    cap[0][rises] = sdata[0];
                    cap[1][rises] = sdata[1];
                end
                if (rises > 0 && s - last_rise != 2 * d) per_err++;
                last_rise = s;
                held = sdata;
                rises++;
            end else if (sclk && sdata !== held) begin
                hold_err++;
            end
            if (sload) begin
                load_len++;
                if (!prev_load) load_pulses++;
                if (sclk) idle_err++;
            end
            if (!busy && (sclk || sload || sdata != 2'b00)) idle_err++;
            prev_clk = sclk;
            prev_load = sload;
            if (stop_rise > 0 && rises == stop_rise) begin
                stopped = 1;
                break;
            end
        end
        if (!stopped) begin
            bad_bits = 0;
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < N; k++) begin
                    io = c * P + P - 1 - k / CW;
                    b  = CW - 1 - k % CW;
                    if (cap[c][k] !== m_cfg[io][b]) bad_bits++;
                end
            end
            n_tests++;
            if (first_busy != 1 || busy_len != d * BUSY1) begin
                n_fail++;
                $display("FAIL busy_window: got start=%0d len=%0d expected 1 %0d",
                         first_busy, busy_len, d * BUSY1);
            end
            n_tests++;
            if (rises != N || per_err != 0 || hold_err != 0) begin
                n_fail++;
                $display("FAIL serial_clock: got rises=%0d per_err=%0d hold_err=%0d expected %0d 0 0",
                         rises, per_err, hold_err, N);
            end
            n_tests++;
            if (load_pulses != 1 || load_len != d) begin
                n_fail++;
                $display("FAIL load_pulse: got pulses=%0d len=%0d expected 1 %0d",
                         load_pulses, load_len, d);
            end
            n_tests++;
            if (bad_bits != 0 || idle_err != 0) begin
                n_fail++;
                $display("FAIL stream: got bad_bits=%0d idle_err=%0d expected 0 0",
                         bad_bits, idle_err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ack !== 0 || busy !== 0 || sclk !== 0 || sload !== 0 ||
            sdata !== 2'b00 || pwr !== 4'h0 || dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b busy=%b sclk=%b load=%b data=%b pwr=%h dat=%h expected all 0",
                     ack, busy, sclk, sload, sdata, pwr, dat_o);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        rd_chk("reset_io0", io_adr(0), 32'h0403);
        rd_chk("reset_io37", io_adr(37), 32'h0403);
        rd_chk("reset_pwr", A_PWR, 32'h0);
    endtask

    task automatic test_pwr();
        logic [31:0] d; logic [3:0] s, e;
        wr_chk("pwr_f", A_PWR, 32'hF, 4'b0001);
        m_pwr = 4'hF;
        n_tests++;
        if (pwr !== 4'hF) begin
            n_fail++;
            $display("FAIL pwr_set: got %h expected f", pwr);
        end
        wr_chk("pwr_nosel", A_PWR, 32'h0, 4'b0000);
        n_tests++;
        if (pwr !== 4'hF) begin
            n_fail++;
            $display("FAIL pwr_nosel: got %h expected f", pwr);
        end
        for (int i = 0; i < 6; i++) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            wr_chk("pwr_rand", A_PWR, d, s);
            e = s[0] ? d[3:0] : m_pwr;
            m_pwr = e;
            n_tests++;
            if (pwr !== m_pwr) begin
                n_fail++;
                $display("FAIL pwr_rand: got %h expected %h", pwr, m_pwr);
            end
        end
        rd_chk("pwr_read", A_PWR, 32'(m_pwr));
    endtask

    task automatic test_io_rw();
        int i; logic [31:0] d, full; logic [3:0] s;
        logic [31:0] rd; logic ok;
        for (int k = 0; k < 30; k++) begin
            i = $urandom_range(0, NIO - 1);
            d = $urandom; s = 4'($urandom_range(0, 15));
            wr_chk("io_wr", io_adr(i), d, s);
            full = bytes_merge(32'(m_cfg[i]), d, s);
            m_cfg[i] = full[12:0];
        end
        for (int k = 0; k < NIO; k++) rd_chk("io_rd", io_adr(k), 32'(m_cfg[k]));
        for (int k = 0; k < 4; k++) begin
            i = $urandom_range(3, 7);
            wr_chk("gap_wr", BASE + 32'(4 * i), $urandom, 4'hF);
            rd_chk("gap_rd", BASE + 32'(4 * i), 32'h0);
            i = $urandom_range(8 + NIO, 1023);
            wr_chk("hi_wr", BASE + 32'(4 * i), $urandom, 4'hF);
            rd_chk("hi_rd", BASE + 32'(4 * i), 32'h0);
        end
        wb_access(1'b0, 32'h2600_1000, 32'h0, 4'hF, rd, ok);
        n_tests++;
        if (ok !== 1'b0) begin
            n_fail++;
            $display("FAIL out_of_range_ack: got %b expected 0", ok);
        end
        wb_access(1'b1, 32'h3000_0004, 32'hF, 4'hF, rd, ok);
        n_tests++;
        if (ok !== 1'b0 || pwr !== m_pwr) begin
            n_fail++;
            $display("FAIL out_of_range_wr: got ack=%b pwr=%h expected 0 %h",
                     ok, pwr, m_pwr);
        end
    endtask

    task automatic test_ack_once();
        int acks;
        acks = 0;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = A_PWR; sel = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 0; stb = 0;
        n_tests++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL ack_once: got %0d acks expected 1", acks);
        end
    endtask

    task automatic test_xfer();
        logic [12:0] c0, c1;
        wr_chk("io18", io_adr(18), 32'h1ABC, 4'hF);
        m_cfg[18] = 13'h1ABC;
        wr_chk("io37", io_adr(37), 32'h0001, 4'hF);
        m_cfg[37] = 13'h0001;
        run_xfer(1, 0);
        for (int k = 0; k < 13; k++) begin
            c0[12 - k] = cap[0][k];
            c1[12 - k] = cap[1][k];
        end
        n_tests++;
        if (c0 !== 13'h1ABC || c1 !== 13'h0001) begin
            n_fail++;
            $display("FAIL first_bits: got %h %h expected 1abc 0001", c0, c1);
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] rd; logic ok; logic [3:0] np; int extra;
        wb_access(1'b1, A_XFER, 32'h1, 4'hF, rd, ok);
        repeat (20) @(posedge clk);
        wr_chk("busy_io5", io_adr(5), 32'(~m_cfg[5]), 4'hF);
        wr_chk("busy_start", A_XFER, 32'h1, 4'hF);
        np = 4'($urandom_range(0, 15));
        wr_chk("busy_pwr", A_PWR, 32'(np), 4'hF);
        m_pwr = np;
        n_tests++;
        if (pwr !== m_pwr) begin
            n_fail++;
            $display("FAIL busy_pwr: got %h expected %h", pwr, m_pwr);
        end
        rd_chk("busy_flag", A_XFER, 32'h1);
        rd_chk("busy_io5_old", io_adr(5), 32'(m_cfg[5]));
        for (int k = 0; k < 700 && busy; k++) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_end: got %b expected 0", busy);
        end
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL second_xfer: got %0d busy cycles expected 0", extra);
        end
        rd_chk("idle_flag", A_XFER, 32'h0);
    endtask

    task automatic test_div();
`ifdef MPRJ_CFG_CLKDIV_EN
        wr_chk("div3", A_DIV, 32'h3, 4'hF);
        rd_chk("div3_rd", A_DIV, 32'h3);
        run_xfer(3, 0);
        wr_chk("div0", A_DIV, 32'h0, 4'hF);
        rd_chk("div0_rd", A_DIV, 32'h0);
        run_xfer(1, 0);
`else
        wr_chk("div3", A_DIV, 32'h3, 4'hF);
        rd_chk("div_rd0", A_DIV, 32'h0);
        run_xfer(1, 0);
`endif
    endtask

    task automatic test_reset_mid();
        run_xfer(1, 100);
        rst = 1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 0 || sclk !== 0 || sload !== 0 || sdata !== 2'b00 ||
            pwr !== 4'h0 || ack !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b sclk=%b load=%b data=%b pwr=%h ack=%b expected all 0",
                     busy, sclk, sload, sdata, pwr, ack);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        rd_chk("mid_io0", io_adr(0), 32'h0403);
        rd_chk("mid_io18", io_adr(18), 32'h0403);
        rd_chk("mid_io37", io_adr(37), 32'h0403);
        run_xfer(1, 0);
    endtask

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
        model_reset();
        test_reset();
        test_pwr();
        test_io_rw();
        test_ack_once();
        test_xfer();
        test_busy_writes();
        test_div();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
